// File: rtl/icache_responder.sv
// ----------------------------------------------------------------------------
// icache_responder
//
// Memory-side responder for the instruction-fetch line-read protocol. Accepts
// line requests on the address channel, forwards them to an in-order backing
// memory port and returns the line (with the original request address) on the
// data channel. Responses always come back in request order; a memory fault is
// reported alongside the line through data_err_o and does not stall the stream.
//
// Ports
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   flush_i             drop every pending and buffered response
//   addr_i / addr_valid_i / addr_ready_o
//                       request channel (byte address, any alignment)
//   data_o / data_addr_o / data_err_o / data_valid_o / data_ready_i
//                       response channel (line, request address, fault)
//   mem_req_o / mem_addr_o / mem_gnt_i
//                       memory request (line-aligned address, grant)
//   mem_rvalid_i / mem_rdata_i / mem_err_i
//                       memory read return, one per grant, in grant order
// ----------------------------------------------------------------------------
module icache_responder #(
    parameter int XLEN   = 64,
    parameter int LINE_W = 128,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic [XLEN-1:0]   addr_i,
    input  logic              addr_valid_i,
    output logic              addr_ready_o,
    output logic [LINE_W-1:0] data_o,
    output logic [XLEN-1:0]   data_addr_o,
    output logic              data_err_o,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic              mem_req_o,
    output logic [XLEN-1:0]   mem_addr_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_err_i
);

    localparam int OFF = $clog2(LINE_W / 8);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    logic [XLEN-1:0]   ent_addr [DEPTH];
    logic [LINE_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_err;
    logic [DEPTH-1:0]  ent_filled;

    logic [PW-1:0] alloc_ptr;
    logic [PW-1:0] fill_ptr;
    logic [PW-1:0] head_ptr;
    logic [CW-1:0] occ;
    logic [CW-1:0] drop_cnt;

    logic [CW-1:0] filled_cnt;
    logic [CW-1:0] unfilled_cnt;
    logic [CW:0]   used_sum;
    logic          credit_ok;
    logic          accept;
    logic          pop;
    logic          fill_en;
    logic          drop_en;

    // Filled bits are only ever set inside the occupied window and are
    // cleared on pop/flush, so occ minus their popcount is the number of
    // allocated entries still waiting on memory.
    always_comb begin
        filled_cnt = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            filled_cnt = filled_cnt + CW'(ent_filled[i]);
        end
        unfilled_cnt = occ - filled_cnt;
    end

    // Credit uses registered counts only: a pop in this cycle does not free
    // a slot until the next one.
    assign used_sum  = {1'b0, occ} + {1'b0, drop_cnt};
    assign credit_ok = (used_sum < DEPTH_W);

    assign mem_req_o    = addr_valid_i & credit_ok & ~flush_i;
    assign addr_ready_o = mem_req_o & mem_gnt_i;
    assign accept       = addr_ready_o;

    always_comb begin
        mem_addr_o          = addr_i;
        mem_addr_o[OFF-1:0] = '0;
    end

    assign data_valid_o = ent_filled[head_ptr] & (occ != '0) & ~flush_i;
    assign data_o       = ent_data[head_ptr];
    assign data_addr_o  = ent_addr[head_ptr];
    assign data_err_o   = ent_err[head_ptr];
    assign pop          = data_valid_o & data_ready_i;

    // Returns still owed to requests abandoned by a flush are swallowed
    // before any return is matched to a live entry.
    assign drop_en = mem_rvalid_i & (drop_cnt != '0);
    assign fill_en = mem_rvalid_i & (drop_cnt == '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            occ        <= '0;
            drop_cnt   <= '0;
            ent_err    <= '0;
            ent_filled <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else if (flush_i) begin
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            occ        <= '0;
            ent_filled <= '0;
            // A return in the flush cycle itself is one of the owed ones.
            drop_cnt   <= drop_cnt + unfilled_cnt - CW'(mem_rvalid_i);
        end else begin
            if (accept) begin
                ent_addr[alloc_ptr]   <= addr_i;
                ent_filled[alloc_ptr] <= 1'b0;
                alloc_ptr             <= alloc_ptr + 1'b1;
            end
            if (pop) begin
                ent_filled[head_ptr] <= 1'b0;
                head_ptr             <= head_ptr + 1'b1;
            end
            if (fill_en) begin
                ent_data[fill_ptr]   <= mem_rdata_i;
                ent_err[fill_ptr]    <= mem_err_i;
                ent_filled[fill_ptr] <= 1'b1;
                fill_ptr             <= fill_ptr + 1'b1;
            end
            if (drop_en) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            occ <= occ + CW'(accept) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_icache_responder.sv
// ----------------------------------------------------------------------------
// tb_icache_responder
//
// Self-checking bench for icache_responder. A behavioural in-order memory
// returns each granted line after a programmable latency; every accepted
// request pushes its expected {addr, line, err} onto a scoreboard that is
// popped on each output handshake and cleared on flush.
// ----------------------------------------------------------------------------
module tb_icache_responder;

    localparam int XLEN   = 64;
    localparam int LINE_W = 128;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst_n;
    logic              flush_i;
    logic [XLEN-1:0]   addr_i;
    logic              addr_valid_i;
    logic              addr_ready_o;
    logic [LINE_W-1:0] data_o;
    logic [XLEN-1:0]   data_addr_o;
    logic              data_err_o;
    logic              data_valid_o;
    logic              data_ready_i;
    logic              mem_req_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic              mem_gnt_i;
    logic              mem_rvalid_i;
    logic [LINE_W-1:0] mem_rdata_i;
    logic              mem_err_i;

    icache_responder #(
        .XLEN   (XLEN),
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .flush_i      (flush_i),
        .addr_i       (addr_i),
        .addr_valid_i (addr_valid_i),
        .addr_ready_o (addr_ready_o),
        .data_o       (data_o),
        .data_addr_o  (data_addr_o),
        .data_err_o   (data_err_o),
        .data_valid_o (data_valid_o),
        .data_ready_i (data_ready_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .mem_err_i    (mem_err_i)
    );

    typedef struct {
        logic [XLEN-1:0]   addr;
        logic [LINE_W-1:0] data;
        logic              err;
    } exp_t;

    typedef struct {
        int                due;
        logic [LINE_W-1:0] data;
        logic              err;
    } mem_t;

    exp_t sb_q[$];
    mem_t mem_q[$];
    int   accept_cycles[$];
    int   resp_cycles[$];

    int n_tests  = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int seq      = 0;
    int lat      = 1;
    int err_seq  = -1;
    int err_seen = 0;

    logic              hold_pend;
    logic [LINE_W-1:0] hold_data;
    logic [XLEN-1:0]   hold_addr;
    logic              hold_err;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [LINE_W-1:0] line_of(input int s);
        logic [31:0] w;
        w = 32'(s);
        return {32'hA5A5_0000 | w, 32'h5A5A_0000 ^ w, ~w, w * 32'h0101_0101};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor, scoreboard and memory model; all observation mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            mem_q.delete();
            hold_pend    = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            mem_err_i    = 1'b0;
        end else begin
            cyc++;
            if (hold_pend && !flush_i) begin
                check("hold_valid", 128'(data_valid_o), 128'(1'b1));
                check("hold_data", 128'(data_o), 128'(hold_data));
                check("hold_addr", 128'(data_addr_o), 128'(hold_addr));
                check("hold_err", 128'(data_err_o), 128'(hold_err));
            end
            hold_pend = data_valid_o && !data_ready_i;
            hold_data = data_o;
            hold_addr = data_addr_o;
            hold_err  = data_err_o;

            if (data_valid_o && data_ready_i) begin
                resp_cycles.push_back(cyc);
                check("sb_nonempty", 128'(sb_q.size() != 0), 128'(1'b1));
                if (sb_q.size() != 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("resp_addr", 128'(data_addr_o), 128'(e.addr));
                    check("resp_data", 128'(data_o), 128'(e.data));
                    check("resp_err", 128'(data_err_o), 128'(e.err));
                    if (data_err_o) err_seen++;
                end
            end
            if (flush_i) sb_q.delete();

            if (mem_req_o && mem_gnt_i) begin
                sb_q.push_back('{addr_i, line_of(seq), (seq == err_seq)});
                mem_q.push_back('{cyc + lat, line_of(seq), (seq == err_seq)});
                accept_cycles.push_back(cyc);
                seq++;
            end

            if (mem_rvalid_i && mem_q.size() != 0) mem_q.delete(0);
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            mem_err_i    = 1'b0;
            if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_q[0].data;
                mem_err_i    = mem_q[0].err;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds a request until accepted; returns at +1 after the accepting edge.
    task automatic issue(input logic [XLEN-1:0] a);
        int k;
        k = 0;
        addr_i       = a;
        addr_valid_i = 1'b1;
        #1;
        while (!addr_ready_o && k < 50) begin
            @(posedge clk);
            #2;
            k++;
        end
        check("issue_ready", 128'(addr_ready_o), 128'(1'b1));
        @(posedge clk);
        #1;
        addr_valid_i = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k;
        k = 0;
        data_ready_i = 1'b1;
        while ((sb_q.size() != 0 || mem_q.size() != 0) && k < 200) begin
            step();
            k++;
        end
        check({"drain_", tag}, 128'(sb_q.size()), 128'(0));
    endtask

    function automatic int count_gaps(input int q[$]);
        int g;
        g = 0;
        for (int i = 1; i < q.size(); i++) begin
            if (q[i] - q[i-1] != 1) g++;
        end
        return g;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t exceeded limit 200000", $time);
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        flush_i      = 1'b0;
        addr_i       = '0;
        addr_valid_i = 1'b0;
        data_ready_i = 1'b0;
        mem_gnt_i    = 1'b0;
        step();
        step();
        check("rst_addr_ready", 128'(addr_ready_o), 128'(1'b0));
        check("rst_mem_req", 128'(mem_req_o), 128'(1'b0));
        check("rst_data_valid", 128'(data_valid_o), 128'(1'b0));
        check("rst_data", 128'(data_o), 128'(0));
        check("rst_data_addr", 128'(data_addr_o), 128'(0));
        check("rst_data_err", 128'(data_err_o), 128'(1'b0));
        rst_n = 1'b1;
        step();

        // Single request, L=1
        lat          = 1;
        mem_gnt_i    = 1'b1;
        data_ready_i = 1'b1;
        addr_i       = 64'h1004;
        addr_valid_i = 1'b1;
        #1;
        check("single_mem_addr", 128'(mem_addr_o), 128'(64'h1000));
        check("single_req", 128'(mem_req_o), 128'(1'b1));
        @(posedge clk);
        #1;
        addr_valid_i = 1'b0;
        check("single_n1_valid", 128'(data_valid_o), 128'(1'b0));
        step();
        check("single_n2_valid", 128'(data_valid_o), 128'(1'b1));
        check("single_n2_addr", 128'(data_addr_o), 128'(64'h1004));
        check("single_n2_err", 128'(data_err_o), 128'(1'b0));
        check("single_n2_data", 128'(data_o), 128'(line_of(0)));
        step();
        check("single_n3_valid", 128'(data_valid_o), 128'(1'b0));
        drain("single");

        // Streaming: 8 back-to-back, L=1, ready high
        accept_cycles.delete();
        resp_cycles.delete();
        for (int i = 0; i < 8; i++) issue(64'h4000 + 64'(i * 16 + i));
        drain("stream");
        check("stream_accepts", 128'(accept_cycles.size()), 128'(8));
        check("stream_acc_gaps", 128'(count_gaps(accept_cycles)), 128'(0));
        check("stream_resps", 128'(resp_cycles.size()), 128'(8));
        check("stream_resp_gaps", 128'(count_gaps(resp_cycles)), 128'(0));
        if (resp_cycles.size() != 0 && accept_cycles.size() != 0)
            check("stream_latency", 128'(resp_cycles[0] - accept_cycles[0]), 128'(2));

        // Backpressure: fill the buffer, then one-cycle ready
        data_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) issue(64'h5000 + 64'(i * 16));
        step();
        step();
        addr_i       = 64'h5100;
        addr_valid_i = 1'b1;
        #1;
        check("bp_full_ready", 128'(addr_ready_o), 128'(1'b0));
        check("bp_full_req", 128'(mem_req_o), 128'(1'b0));
        check("bp_head_valid", 128'(data_valid_o), 128'(1'b1));
        data_ready_i = 1'b1;
        #1;
        check("bp_no_bypass", 128'(addr_ready_o), 128'(1'b0));
        @(posedge clk);
        #1;
        data_ready_i = 1'b0;
        #1;
        check("bp_rise", 128'(addr_ready_o), 128'(1'b1));
        @(posedge clk);
        #1;
        addr_valid_i = 1'b0;
        drain("bp");

        // Flush with 3 in flight, L=5
        lat = 5;
        for (int i = 0; i < 3; i++) issue(64'h6000 + 64'(i * 16));
        resp_cycles.delete();
        addr_i       = 64'h7008;
        addr_valid_i = 1'b1;
        flush_i      = 1'b1;
        #1;
        check("flush_req_gated", 128'(mem_req_o), 128'(1'b0));
        check("flush_valid_gated", 128'(data_valid_o), 128'(1'b0));
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        check("flush_drop3", 128'(dut.drop_cnt), 128'(3));
        #1;
        check("flush_next_ready", 128'(addr_ready_o), 128'(1'b1));
        @(posedge clk);
        #1;
        addr_valid_i = 1'b0;
        drain("flush1");
        check("flush_drop0", 128'(dut.drop_cnt), 128'(0));
        check("flush_one_resp", 128'(resp_cycles.size()), 128'(1));

        // Flush coinciding with a memory return, 2 unfilled, L=3
        lat = 3;
        issue(64'h8000);
        issue(64'h8010);
        resp_cycles.delete();
        step();
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        check("flushrv_drop1", 128'(dut.drop_cnt), 128'(1));
        step();
        check("flushrv_drop0", 128'(dut.drop_cnt), 128'(0));
        check("flushrv_no_valid", 128'(data_valid_o), 128'(1'b0));
        drain("flushrv");
        check("flushrv_no_resp", 128'(resp_cycles.size()), 128'(0));
        lat = 1;
        issue(64'h8100);
        drain("flushrv_after");
        check("flushrv_after_resp", 128'(resp_cycles.size()), 128'(1));

        // Fault on the 2nd of 3 responses
        err_seen = 0;
        err_seq  = seq + 1;
        for (int i = 0; i < 3; i++) issue(64'h9000 + 64'(i * 16));
        drain("fault");
        check("fault_count", 128'(err_seen), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
